// File: rtl/sram_1r1w_tiled.sv
// sram_1r1w_tiled: WIDTH x DEPTH 1R1W RAM tiled from 1r1w macros, 2-cycle read.
// Optional SRAM_COLLISION_FWD_EN forwards full-width colliding writes.
module sram_1r1w_tiled_macro #(
   parameter int MW = 32,
   parameter int MD = 64,
   parameter int AW = $clog2(MD)
) (
   input  logic          clk,
   input  logic          csb0,
   input  logic [AW-1:0] addr0,
   input  logic [MW-1:0] din0,
   input  logic [MW-1:0] ben0,
   input  logic          csb1,
   input  logic [AW-1:0] addr1,
   output logic [MW-1:0] dout1
);
   logic [MW-1:0] mem [MD];
   logic [MW-1:0] dout_q;

   always_ff @(posedge clk) begin
      if (!csb0) mem[addr0] <= (mem[addr0] & ~ben0) | (din0 & ben0);
      if (!csb1) dout_q <= mem[addr1];
   end

   assign dout1 = dout_q;
endmodule

module sram_1r1w_tiled #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 64,
   parameter int BYTE_WIDTH  = 0,
   parameter int MACRO_WIDTH = 32,
   parameter int MACRO_DEPTH = 64,
   parameter int ADDR_WIDTH  = $clog2(DEPTH),
   parameter int MASK_WIDTH  = (BYTE_WIDTH != 0) ?
                               WIDTH / ((BYTE_WIDTH != 0) ? BYTE_WIDTH : 1) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [MASK_WIDTH-1:0] wmask,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic                  r_ready,
   output logic                  rvalid,
   output logic [WIDTH-1:0]      rdata
);
   localparam int COLS = (WIDTH + MACRO_WIDTH - 1) / MACRO_WIDTH;
   localparam int ROWS = DEPTH / MACRO_DEPTH;
   localparam int MA   = $clog2(MACRO_DEPTH);
   localparam int RSW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int PW   = COLS * MACRO_WIDTH;
   localparam int BW1  = (BYTE_WIDTH != 0) ? BYTE_WIDTH : 1;

   typedef enum logic {IDLE, REPLAY} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rp_addr_q, rp_addr_d;
   logic                  p1_valid_q, p1_valid_d;
   logic [RSW-1:0]        p1_row_q, p1_row_d;
   logic                  rvalid_q, rvalid_d;
   logic [WIDTH-1:0]      rdata_q, rdata_d;

   logic                  rd_issue;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  coll, fwd, replay;
   logic [RSW-1:0]        wrow, rrow;
   logic [MA-1:0]         wlo, rlo;
   logic [ROWS-1:0]       wcsb, rcsb;
   logic [PW-1:0]         wdata_pad, wben, mux_pad;
   logic [ROWS*PW-1:0]    dout_flat;
   logic [WIDTH-1:0]      rd_word;
   logic                  unused_ok;

   // A replay owns the read port; the external request is ignored meanwhile.
   always_comb begin
      rd_issue = (state_q == REPLAY) || re;
      rd_addr  = (state_q == REPLAY) ? rp_addr_q : raddr;
   end

   assign coll   = rd_issue && we && (rd_addr == waddr);
   assign replay = coll && !fwd;
   assign wrow   = RSW'(waddr >> MA);
   assign rrow   = RSW'(rd_addr >> MA);
   assign wlo    = MA'(waddr);
   assign rlo    = MA'(rd_addr);

   always_comb begin
      wdata_pad = '0;
      wdata_pad[WIDTH-1:0] = wdata;
   end

   if (BYTE_WIDTH == 0) begin : g_nomask
      always_comb begin
         wben = '0;
         wben[WIDTH-1:0] = '1;
      end
   end else begin : g_mask
      always_comb begin
         wben = '0;
         for (int b = 0; b < WIDTH; b++) wben[b] = wmask[b / BW1];
      end
   end

   always_comb begin
      wcsb = '1;
      rcsb = '1;
      for (int r = 0; r < ROWS; r++) begin
         wcsb[r] = !(we && (wrow == RSW'(r)));
         rcsb[r] = !(rd_issue && (rrow == RSW'(r)));
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         localparam int LO = r * PW + c * MACRO_WIDTH;
`ifdef SYNTHESIS
         if (MACRO_WIDTH == 32 && MACRO_DEPTH == 64 && BYTE_WIDTH == 8) begin : g_m8
            logic [3:0] bmask;
            for (genvar k = 0; k < 4; k++) begin : g_bm
               assign bmask[k] = wben[c * 32 + 8 * k];
            end
            sky130_sram_1r1w0rw_32x64_8 u_macro (
               .clk0(clk), .csb0(wcsb[r]), .wmask0(bmask),
               .addr0(wlo), .din0(wdata_pad[c*32 +: 32]),
               .clk1(clk), .csb1(rcsb[r]), .addr1(rlo),
               .dout1(dout_flat[LO +: 32])
            );
         end else if (MACRO_WIDTH == 32 && MACRO_DEPTH == 64 && BYTE_WIDTH == 0) begin : g_m
            sky130_sram_1r1w0rw_32x64 u_macro (
               .clk0(clk), .csb0(wcsb[r]),
               .addr0(wlo), .din0(wdata_pad[c*32 +: 32]),
               .clk1(clk), .csb1(rcsb[r]), .addr1(rlo),
               .dout1(dout_flat[LO +: 32])
            );
         end else begin : g_beh
            sram_1r1w_tiled_macro #(.MW(MACRO_WIDTH), .MD(MACRO_DEPTH)) u_macro (
               .clk(clk), .csb0(wcsb[r]), .addr0(wlo),
               .din0(wdata_pad[c*MACRO_WIDTH +: MACRO_WIDTH]),
               .ben0(wben[c*MACRO_WIDTH +: MACRO_WIDTH]),
               .csb1(rcsb[r]), .addr1(rlo),
               .dout1(dout_flat[LO +: MACRO_WIDTH])
            );
         end
`else
         sram_1r1w_tiled_macro #(.MW(MACRO_WIDTH), .MD(MACRO_DEPTH)) u_macro (
            .clk(clk), .csb0(wcsb[r]), .addr0(wlo),
            .din0(wdata_pad[c*MACRO_WIDTH +: MACRO_WIDTH]),
            .ben0(wben[c*MACRO_WIDTH +: MACRO_WIDTH]),
            .csb1(rcsb[r]), .addr1(rlo),
            .dout1(dout_flat[LO +: MACRO_WIDTH])
         );
`endif
      end
   end

   always_comb begin
      mux_pad = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (p1_row_q == RSW'(r)) mux_pad = dout_flat[r*PW +: PW];
      end
   end

`ifdef SRAM_COLLISION_FWD_EN
   logic             full_w;
   logic             p1_fwd_q, p1_fwd_d;
   logic [WIDTH-1:0] p1_fdata_q, p1_fdata_d;

   assign full_w = (BYTE_WIDTH == 0) || (&wmask);
   assign fwd    = coll && full_w;

   always_comb begin
      p1_fwd_d   = fwd;
      p1_fdata_d = wdata;
      rd_word    = p1_fwd_q ? p1_fdata_q : mux_pad[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p1_fwd_q   <= 1'b0;
         p1_fdata_q <= '0;
      end else begin
         p1_fwd_q   <= p1_fwd_d;
         p1_fdata_q <= p1_fdata_d;
      end
   end
`else
   assign fwd     = 1'b0;
   assign rd_word = mux_pad[WIDTH-1:0];
`endif

   always_comb begin
      state_d    = replay ? REPLAY : IDLE;
      rp_addr_d  = replay ? rd_addr : rp_addr_q;
      p1_valid_d = rd_issue && !replay;
      p1_row_d   = rrow;
      rvalid_d   = p1_valid_q;
      rdata_d    = rdata_q;
      if (p1_valid_q) rdata_d = rd_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rp_addr_q  <= '0;
         p1_valid_q <= 1'b0;
         p1_row_q   <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         rp_addr_q  <= rp_addr_d;
         p1_valid_q <= p1_valid_d;
         p1_row_q   <= p1_row_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

   assign r_ready   = (state_q == IDLE);
   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
   assign unused_ok = ^{wmask, mux_pad};
endmodule

// File: tb/tb_sram_1r1w_tiled.sv
// tb_sram_1r1w_tiled: directed vectors for the tiled 1R1W RAM.
// Three instances: 32x64 base, 68x256 (3x4 tiles), 32x64 byte-masked.
module tb_sram_1r1w_tiled;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef SRAM_COLLISION_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        a_we, a_re, a_rdy, a_rv;
   logic        a_wm;
   logic [5:0]  a_wa, a_ra;
   logic [31:0] a_wd, a_rd;

   sram_1r1w_tiled u0 (
      .clk(clk), .rst(rst), .we(a_we), .waddr(a_wa), .wdata(a_wd),
      .wmask(a_wm), .re(a_re), .raddr(a_ra), .r_ready(a_rdy),
      .rvalid(a_rv), .rdata(a_rd)
   );

   logic        b_we, b_re, b_rdy, b_rv;
   logic        b_wm;
   logic [7:0]  b_wa, b_ra;
   logic [67:0] b_wd, b_rd;

   sram_1r1w_tiled #(.WIDTH(68), .DEPTH(256)) u1 (
      .clk(clk), .rst(rst), .we(b_we), .waddr(b_wa), .wdata(b_wd),
      .wmask(b_wm), .re(b_re), .raddr(b_ra), .r_ready(b_rdy),
      .rvalid(b_rv), .rdata(b_rd)
   );

   logic        c_we, c_re, c_rdy, c_rv;
   logic [3:0]  c_wm;
   logic [5:0]  c_wa, c_ra;
   logic [31:0] c_wd, c_rd;

   sram_1r1w_tiled #(.BYTE_WIDTH(8)) u2 (
      .clk(clk), .rst(rst), .we(c_we), .waddr(c_wa), .wdata(c_wd),
      .wmask(c_wm), .re(c_re), .raddr(c_ra), .r_ready(c_rdy),
      .rvalid(c_rv), .rdata(c_rd)
   );

   typedef struct packed {
      logic        we;
      logic [5:0]  wa;
      logic [31:0] wd;
      logic        re;
      logic [5:0]  ra;
      logic        ev;
      logic [31:0] ed;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic a_set(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                        input logic re, input logic [5:0] ra);
      a_we = we; a_wa = wa; a_wd = wd; a_re = re; a_ra = ra;
   endtask

   task automatic c_set(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                        input logic [3:0] wm, input logic re, input logic [5:0] ra);
      c_we = we; c_wa = wa; c_wd = wd; c_wm = wm; c_re = re; c_ra = ra;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [67:0] pat [4];
      logic [7:0]  tad [4];
      logic [3:0]  ecsb;

      a_set(0, 0, 0, 0, 0);
      a_wm = 1'b1;
      b_we = 0; b_wa = 0; b_wd = 0; b_wm = 1'b1; b_re = 0; b_ra = 0;
      c_set(0, 0, 0, 4'h0, 0, 0);

      tbl[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 1'b0, 6'd0,  1'b0, 32'h0};
      tbl[1]  = '{1'b1, 6'd6,  32'h12345678, 1'b0, 6'd0,  1'b0, 32'h0};
      tbl[2]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd5,  1'b0, 32'h0};
      tbl[3]  = '{1'b1, 6'd5,  32'hCAFEF00D, 1'b1, 6'd6,  1'b0, 32'h0};
      tbl[4]  = '{1'b1, 6'd7,  32'h0BADC0DE, 1'b1, 6'd5,  1'b1, 32'hDEADBEEF};
      tbl[5]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd7,  1'b1, 32'h12345678};
      tbl[6]  = '{1'b1, 6'd63, 32'hA5A5A5A5, 1'b0, 6'd0,  1'b1, 32'hCAFEF00D};
      tbl[7]  = '{1'b1, 6'd0,  32'h5A5A5A5A, 1'b1, 6'd63, 1'b1, 32'h0BADC0DE};
      tbl[8]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd0,  1'b0, 32'h0BADC0DE};
      tbl[9]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b1, 32'hA5A5A5A5};
      tbl[10] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b1, 32'h5A5A5A5A};
      tbl[11] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b0, 32'h5A5A5A5A};

      repeat (2) @(negedge clk);
      chk("rst_rv", a_rv, 0);
      chk("rst_rd", a_rd, 0);
      chk("rst_rdy", a_rdy, 1);
      rst = 1'b1;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk($sformatf("tbl%0d_rdy", i), a_rdy, 1);
         chk($sformatf("tbl%0d_rv", i), a_rv, tbl[i].ev);
         chk($sformatf("tbl%0d_rd", i), a_rd, tbl[i].ed);
         a_set(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
      end

      // same-cycle write/read of address 3
      @(negedge clk); a_set(1, 3, 32'h55, 1, 3);
      @(negedge clk);
      chk("coll_rdy1", a_rdy, FWD);
      chk("coll_rv1", a_rv, 0);
      a_set(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("coll_rdy2", a_rdy, 1);
      chk("coll_rv2", a_rv, FWD);
      chk("coll_rd2", a_rd, FWD ? 32'h55 : 32'h5A5A5A5A);
      @(negedge clk);
      chk("coll_rv3", a_rv, !FWD);
      chk("coll_rd3", a_rd, 32'h55);
      @(negedge clk);
      chk("coll_rv4", a_rv, 0);

      // back-to-back reads with a colliding write on the middle one
      @(negedge clk); a_set(1, 1, 32'h1111, 0, 0);
      @(negedge clk); a_set(1, 2, 32'h2222, 0, 0);
      @(negedge clk); a_set(1, 3, 32'h3333, 0, 0);
      @(negedge clk); a_set(0, 0, 0, 1, 1);
      @(negedge clk);
      chk("b2b_rdy1", a_rdy, 1);
      a_set(1, 2, 32'h2BAD, 1, 2);
      @(negedge clk);
      chk("b2b_rdy2", a_rdy, FWD);
      chk("b2b_rv2", a_rv, 1);
      chk("b2b_rd2", a_rd, 32'h1111);
      a_set(0, 0, 0, 1, 3);
`ifdef SRAM_COLLISION_FWD_EN
      @(negedge clk);
      chk("b2b_rv3", a_rv, 1);
      chk("b2b_rd3", a_rd, 32'h2BAD);
      a_set(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("b2b_rv4", a_rv, 1);
      chk("b2b_rd4", a_rd, 32'h3333);
      @(negedge clk);
      chk("b2b_rv5", a_rv, 0);
`else
      @(negedge clk);
      chk("b2b_rdy3", a_rdy, 1);
      chk("b2b_rv3", a_rv, 0);
      a_set(0, 0, 0, 1, 3);
      @(negedge clk);
      chk("b2b_rv4", a_rv, 1);
      chk("b2b_rd4", a_rd, 32'h2BAD);
      a_set(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("b2b_rv5", a_rv, 1);
      chk("b2b_rd5", a_rd, 32'h3333);
      @(negedge clk);
      chk("b2b_rv6", a_rv, 0);
`endif

      // replay that collides again with a new write
      @(negedge clk); a_set(1, 4, 32'h44, 1, 4);
`ifdef SRAM_COLLISION_FWD_EN
      @(negedge clk);
      chk("rr_rdy1", a_rdy, 1);
      chk("rr_rv1", a_rv, 0);
      a_set(1, 4, 32'h77, 0, 0);
      @(negedge clk);
      chk("rr_rv2", a_rv, 1);
      chk("rr_rd2", a_rd, 32'h44);
      a_set(0, 0, 0, 0, 0);
`else
      @(negedge clk);
      chk("rr_rdy1", a_rdy, 0);
      a_set(1, 4, 32'h77, 0, 0);
      @(negedge clk);
      chk("rr_rdy2", a_rdy, 0);
      chk("rr_rv2", a_rv, 0);
      a_set(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rr_rdy3", a_rdy, 1);
      chk("rr_rv3", a_rv, 0);
      @(negedge clk);
      chk("rr_rv4", a_rv, 1);
      chk("rr_rd4", a_rd, 32'h77);
`endif

      // 68-bit tiling across columns and rows
      pat[0] = 68'hF_0123_4567_89AB_CDEF; tad[0] = 8'd0;
      pat[1] = 68'h1_FEDC_BA98_7654_3210; tad[1] = 8'd63;
      pat[2] = 68'hA_5555_AAAA_3333_CCCC; tad[2] = 8'd64;
      pat[3] = 68'h5_0F0F_0F0F_F0F0_F0F0; tad[3] = 8'd255;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b_we = 1'b1; b_wa = tad[i]; b_wd = pat[i];
         #1;
         ecsb = ~(4'b0001 << tad[i][7:6]);
         chk($sformatf("tile_wcsb%0d", i), u1.wcsb, ecsb);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            chk($sformatf("tile_rv%0d", i - 2), b_rv, 1);
            chk($sformatf("tile_rd%0d", i - 2), b_rd, pat[i-2]);
         end
         b_we = 1'b0;
         b_re = (i < 4);
         b_ra = (i < 4) ? tad[i] : 8'd0;
         #1;
         ecsb = (i < 4) ? ~(4'b0001 << tad[i][7:6]) : 4'hF;
         chk($sformatf("tile_rcsb%0d", i), u1.rcsb, ecsb);
      end
      b_re = 1'b0;

      // byte-masked writes and a partial-mask collision
      @(negedge clk); c_set(1, 9, 32'h11223344, 4'hF, 0, 0);
      @(negedge clk); c_set(1, 9, 32'hAABBCCDD, 4'h5, 0, 0);
      @(negedge clk); c_set(0, 0, 0, 4'h0, 1, 9);
      @(negedge clk); c_set(0, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      chk("mask_rv", c_rv, 1);
      chk("mask_rd", c_rd, 32'h11BB33DD);
      c_set(1, 9, 32'hFFFFFFFF, 4'h1, 1, 9);
      @(negedge clk);
      chk("pcoll_rdy1", c_rdy, 0);
      chk("pcoll_rv1", c_rv, 0);
      c_set(0, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      chk("pcoll_rdy2", c_rdy, 1);
      chk("pcoll_rv2", c_rv, 0);
      @(negedge clk);
      chk("pcoll_rv3", c_rv, 1);
      chk("pcoll_rd3", c_rd, 32'h11BB33FF);

      // asynchronous reset with reads in flight
      @(negedge clk); a_set(0, 0, 0, 1, 5);
      @(posedge clk); #1 a_set(0, 0, 0, 1, 6);
      @(posedge clk); #1 a_set(0, 0, 0, 1, 7);
      chk("pre_rst_rv", a_rv, 1);
      chk("pre_rst_rd", a_rd, 32'hCAFEF00D);
      #2 rst = 1'b0;
      #1;
      chk("arst_rv", a_rv, 0);
      chk("arst_rd", a_rd, 0);
      chk("arst_rdy", a_rdy, 1);
      a_set(0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_rv1", a_rv, 0);
      a_set(0, 0, 0, 1, 5);
      @(negedge clk);
      chk("post_rst_rv2", a_rv, 0);
      a_set(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("post_rst_rv3", a_rv, 1);
      chk("post_rst_rd3", a_rd, 32'hCAFEF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
